// File: rtl/pc_sequencer_if.sv
// Front-end PC sequencer bus: hazard/imem/branch inputs and PC/select outputs.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH = 64
);
  logic                stall;
  logic                imem_ready;
  logic                br_valid;
  logic                br_is_cond;
  logic                br_cond;
  logic                br_uncond;
  logic                br_is_reg;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] norm_result;
  logic                UncondBr;
  logic                BrTaken;
  logic                is_BR;
  logic                fetch_valid;
  logic                flush;
  logic                pc_misalign;

  modport master (
    output stall, imem_ready, br_valid, br_is_cond, br_cond, br_uncond, br_is_reg, next_pc,
    input  pc_reg, norm_result, UncondBr, BrTaken, is_BR, fetch_valid, flush, pc_misalign
  );

  modport slave (
    input  stall, imem_ready, br_valid, br_is_cond, br_cond, br_uncond, br_is_reg, next_pc,
    output pc_reg, norm_result, UncondBr, BrTaken, is_BR, fetch_valid, flush, pc_misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register, next-PC select generation and post-redirect flush window.
// Optional feature macro: PC_MISALIGN_CHK_EN (align redirect targets, sticky pc_misalign).
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                flush_q;
  logic                taken;
  logic [PC_WIDTH-1:0] redirect_pc;

  always_comb begin
    taken = bus.br_valid & (state_q == StFetch) &
            (bus.br_is_reg | bus.br_uncond | (bus.br_is_cond & bus.br_cond));
  end

  // br_is_reg outranks br_uncond, which outranks br_is_cond.
  assign bus.is_BR    = taken & bus.br_is_reg;
  assign bus.BrTaken  = taken & ~bus.br_is_reg;
  assign bus.UncondBr = taken & ~bus.br_is_reg & bus.br_uncond;

  assign bus.pc_reg      = pc_q;
  assign bus.norm_result = pc_q + PC_WIDTH'(4);
  assign bus.flush       = flush_q;
  assign bus.fetch_valid = reset & (state_q == StFetch);

`ifdef PC_MISALIGN_CHK_EN
  logic mis_q;
  assign redirect_pc     = {bus.next_pc[PC_WIDTH-1:2], 2'b00};
  assign bus.pc_misalign = mis_q;
`else
  assign redirect_pc     = bus.next_pc;
  assign bus.pc_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (taken) begin
            // Redirect wins over stall and imem backpressure.
            pc_q    <= redirect_pc;
            state_q <= StFlush;
            flush_q <= 1'b1;
            cnt_q   <= 4'(FLUSH_CYCLES - 1);
`ifdef PC_MISALIGN_CHK_EN
            if (bus.next_pc[1:0] != 2'b00) mis_q <= 1'b1;
`endif
          end else if (!bus.stall && bus.imem_ready) begin
            pc_q <= bus.next_pc;
          end
        end
        StFlush: begin
          if (cnt_q == 4'd0) begin
            state_q <= StFetch;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a per-cycle expectation scoreboard.
module tb_pc_sequencer;

  localparam int unsigned W = 64;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [W-1:0] MisTgt = 64'h100;
  localparam logic         MisExp = 1'b1;
`else
  localparam logic [W-1:0] MisTgt = 64'h102;
  localparam logic         MisExp = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] pc;
    logic         fv;
    logic         fl;
    logic         mis;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] tgt;
  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] epc;
  logic         emis;

  pc_sequencer_if #(.PC_WIDTH(W)) bus ();

  pc_sequencer #(.PC_WIDTH(W), .RESET_PC(64'h0), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External next-PC mux driven by the DUT's selects.
  assign bus.next_pc = (bus.BrTaken | bus.is_BR) ? tgt : bus.norm_result;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sel(input logic ub, input logic bt, input logic ir);
    #1;
    chk("UncondBr", W'(bus.UncondBr), W'(ub));
    chk("BrTaken", W'(bus.BrTaken), W'(bt));
    chk("is_BR", W'(bus.is_BR), W'(ir));
  endtask

  // Push the expected post-edge state, advance to the next negedge, pop and compare.
  task automatic cyc(input logic [W-1:0] pc, input logic fv, input logic fl, input logic mis);
    exp_t e;
    sb.push_back('{pc: pc, fv: fv, fl: fl, mis: mis});
    @(negedge clk);
    e = sb.pop_front();
    chk("pc_reg", bus.pc_reg, e.pc);
    chk("fetch_valid", W'(bus.fetch_valid), W'(e.fv));
    chk("flush", W'(bus.flush), W'(e.fl));
    chk("pc_misalign", W'(bus.pc_misalign), W'(e.mis));
  endtask

  task automatic clr_br();
    bus.br_valid = 0; bus.br_is_cond = 0; bus.br_cond = 0; bus.br_uncond = 0; bus.br_is_reg = 0;
  endtask

  initial begin
    reset = 0; tgt = '0;
    bus.stall = 0; bus.imem_ready = 1;
    clr_br();

    // Reset, idle, then sequential fetch
    repeat (3) cyc(64'h0, 0, 0, 0);
    reset = 1;
    #1 chk("idle_fv", W'(bus.fetch_valid), W'(0));
    cyc(64'h0, 1, 0, 0);
    cyc(64'h4, 1, 0, 0);
    cyc(64'h8, 1, 0, 0);

    // Stall and imem backpressure hold the PC
    bus.stall = 1;
    cyc(64'h8, 1, 0, 0);
    cyc(64'h8, 1, 0, 0);
    bus.stall = 0;
    cyc(64'hC, 1, 0, 0);
    bus.imem_ready = 0;
    cyc(64'hC, 1, 0, 0);
    bus.imem_ready = 1;
    cyc(64'h10, 1, 0, 0);

    // Not-taken conditional
    bus.br_valid = 1; bus.br_is_cond = 1; bus.br_cond = 0;
    sel(0, 0, 0);
    chk("nt_next_pc", bus.next_pc, 64'h14);
    cyc(64'h14, 1, 0, 0);
    clr_br();

    // Unconditional redirect under stall
    bus.br_valid = 1; bus.br_uncond = 1; bus.stall = 1; tgt = 64'h100;
    sel(1, 1, 0);
    cyc(64'h100, 0, 1, 0);
    tgt = 64'h500;
    sel(0, 0, 0);
    cyc(64'h100, 0, 1, 0);
    bus.stall = 0;
    tgt = 64'h200;
    cyc(64'h100, 1, 0, 0);

    // Branch held in the first fetch cycle after flush is honoured
    sel(1, 1, 0);
    cyc(64'h200, 0, 1, 0);
    clr_br();
    cyc(64'h200, 0, 1, 0);
    cyc(64'h200, 1, 0, 0);
    cyc(64'h204, 1, 0, 0);

    // Register branch wins over uncond; reset aborts the flush window
    bus.br_valid = 1; bus.br_is_reg = 1; bus.br_uncond = 1; tgt = 64'h2000;
    sel(0, 0, 1);
    cyc(64'h2000, 0, 1, 0);
    clr_br();
    reset = 0;
    cyc(64'h0, 0, 0, 0);
    reset = 1;
    #1 chk("idle2_fv", W'(bus.fetch_valid), W'(0));
    cyc(64'h0, 1, 0, 0);

    // Misaligned redirect target
    bus.br_valid = 1; bus.br_uncond = 1; tgt = 64'h102;
    sel(1, 1, 0);
    cyc(MisTgt, 0, 1, MisExp);
    clr_br();
    cyc(MisTgt, 0, 1, MisExp);
    epc = MisTgt;
    emis = MisExp;
    cyc(epc, 1, 0, emis);
    for (int i = 0; i < 9; i++) begin
      epc = epc + 64'd4;
      cyc(epc, 1, 0, emis);
    end

    // Wrap from top of address space to zero
    bus.br_valid = 1; bus.br_is_reg = 1; tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    sel(0, 0, 1);
    cyc(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, emis);
    clr_br();
    cyc(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, emis);
    cyc(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, emis);
    chk("wrap_norm", bus.norm_result, 64'h0);
    cyc(64'h0, 1, 0, emis);
    cyc(64'h4, 1, 0, emis);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
